// File: rtl/unisys_trace_pkg.sv
// Shared definitions for the PC trace buffer: register map, CTRL/STATUS bit
// positions and the capture FSM encoding.
package unisys_trace_pkg;

  localparam logic [4:0] REG_CTRL      = 5'h00;
  localparam logic [4:0] REG_STATUS    = 5'h04;
  localparam logic [4:0] REG_TRIG_PC   = 5'h08;
  localparam logic [4:0] REG_READ_IDX  = 5'h0C;
  localparam logic [4:0] REG_READ_DATA = 5'h10;

  localparam int unsigned CTRL_EN_BIT      = 0;
  localparam int unsigned CTRL_MODE_BIT    = 1;
  localparam int unsigned CTRL_CLR_BIT     = 2;
  localparam int unsigned CTRL_TRIG_EN_BIT = 3;

  localparam int unsigned ST_COUNT_W   = 16;
  localparam int unsigned ST_FULL_BIT  = 16;
  localparam int unsigned ST_OVF_BIT   = 17;
  localparam int unsigned ST_FSM_LSB   = 18;
  localparam int unsigned ST_W         = 20;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_STOPPED = 2'd3
  } trace_state_e;

  typedef struct packed {
    logic trig_en;
    logic mode;
    logic en;
  } ctrl_t;

endpackage

// File: rtl/trace_ram.sv
// Trace storage: one synchronous write port, one combinational read port.
// Contents are intentionally not reset.
module trace_ram #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 64,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [AW-1:0]   raddr_i,
  output logic [XLEN-1:0] rdata_o
);

  logic [XLEN-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/pc_trace_buf.sv
// PC trace buffer: records the PC on each entry into the fetch state into a
// circular buffer, controlled and read back through a small register slave.
module pc_trace_buf
  import unisys_trace_pkg::*;
#(
  parameter int unsigned        XLEN        = 32,
  parameter int unsigned        DEPTH       = 64,
  parameter int unsigned        STATE_W     = 5,
  parameter logic [STATE_W-1:0] FETCH_STATE = STATE_W'(1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STATE_W-1:0] core_state,
  input  logic [XLEN-1:0]    pc,
  input  logic               bus_req,
  input  logic               bus_wen,
  input  logic [4:0]         bus_addr,
  input  logic [XLEN-1:0]    bus_dat_i,
  output logic [XLEN-1:0]    bus_dat_o,
  output logic               bus_ready
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  ctrl_t             ctrl_q, ctrl_d;
  logic [XLEN-1:0]   trig_pc_q, trig_pc_d;
  logic [XLEN-1:0]   read_idx_q, read_idx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     optr_q, optr_d;
  logic              ovf_q, ovf_d;
  trace_state_e      state_q, state_d;
  logic [STATE_W-1:0] prev_state_q, prev_state_d;
  logic              ready_q, ready_d;
  logic [XLEN-1:0]   dat_q, dat_d;

  logic              rd_fire, wr_fire, clr_wr, fetch_evt, full, accept, ram_we;
  logic [4:0]        reg_off;
  ctrl_t             new_ctrl;
  logic [ST_W-1:0]   status_w;
  logic [XLEN-1:0]   ctrl_rd, read_data_w, ram_rdata;
  logic [AW-1:0]     ram_raddr;
  logic              unused_addr;

  assign unused_addr = ^bus_addr[1:0];
  assign reg_off     = {bus_addr[4:2], 2'b00};
  assign wr_fire     = bus_req & ~ready_q & bus_wen;
  assign rd_fire     = bus_req & ~ready_q & ~bus_wen;
  assign clr_wr      = wr_fire && (reg_off == REG_CTRL) && bus_dat_i[CTRL_CLR_BIT];
  assign fetch_evt   = (core_state == FETCH_STATE) && (prev_state_q != FETCH_STATE);
  assign full        = (cnt_q == CW'(DEPTH));

  assign new_ctrl.en      = bus_dat_i[CTRL_EN_BIT];
  assign new_ctrl.mode    = bus_dat_i[CTRL_MODE_BIT];
  assign new_ctrl.trig_en = bus_dat_i[CTRL_TRIG_EN_BIT];

  // READ_DATA is indexed relative to the oldest entry; out-of-range reads 0.
  assign ram_raddr   = optr_q + read_idx_q[AW-1:0];
  assign read_data_w = (read_idx_q < XLEN'(cnt_q)) ? ram_rdata : '0;

  always_comb begin
    status_w                       = '0;
    status_w[ST_COUNT_W-1:0]       = ST_COUNT_W'(cnt_q);
    status_w[ST_FULL_BIT]          = full;
    status_w[ST_OVF_BIT]           = ovf_q;
    status_w[ST_FSM_LSB +: 2]      = state_q;
    ctrl_rd                        = '0;
    ctrl_rd[CTRL_EN_BIT]           = ctrl_q.en;
    ctrl_rd[CTRL_MODE_BIT]         = ctrl_q.mode;
    ctrl_rd[CTRL_TRIG_EN_BIT]      = ctrl_q.trig_en;
  end

  trace_ram #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (wptr_q),
    .wdata_i (pc),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  // Bus slave, register writes and capture FSM; all decisions use pre-write state.
  always_comb begin
    ctrl_d       = ctrl_q;
    trig_pc_d    = trig_pc_q;
    read_idx_d   = read_idx_q;
    cnt_d        = cnt_q;
    wptr_d       = wptr_q;
    optr_d       = optr_q;
    ovf_d        = ovf_q;
    state_d      = state_q;
    prev_state_d = core_state;
    ready_d      = bus_req & ~ready_q;
    dat_d        = '0;
    ram_we       = 1'b0;
    accept       = 1'b0;

    if (rd_fire) begin
      case (reg_off)
        REG_CTRL:      dat_d = ctrl_rd;
        REG_STATUS:    dat_d = XLEN'(status_w);
        REG_TRIG_PC:   dat_d = trig_pc_q;
        REG_READ_IDX:  dat_d = read_idx_q;
        REG_READ_DATA: dat_d = read_data_w;
        default:       dat_d = '0;
      endcase
    end

    if (wr_fire) begin
      case (reg_off)
        REG_CTRL:     ctrl_d     = new_ctrl;
        REG_TRIG_PC:  trig_pc_d  = bus_dat_i;
        REG_READ_IDX: read_idx_d = bus_dat_i;
        default: ;
      endcase
    end

    if (clr_wr) begin
      cnt_d  = '0;
      wptr_d = '0;
      optr_d = '0;
      ovf_d  = 1'b0;
      if (!new_ctrl.en)          state_d = ST_IDLE;
      else if (new_ctrl.trig_en) state_d = ST_ARMED;
      else                       state_d = ST_CAPTURE;
    end else if (!ctrl_q.en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    state_d = ctrl_q.trig_en ? ST_ARMED : ST_CAPTURE;
        ST_ARMED:   accept  = fetch_evt && (pc == trig_pc_q);
        ST_CAPTURE: accept  = fetch_evt;
        default: ;
      endcase
      if (accept) begin
        if (full && ctrl_q.mode) begin
          state_d = ST_STOPPED;
          ovf_d   = 1'b1;
        end else begin
          state_d = ST_CAPTURE;
          ram_we  = 1'b1;
          wptr_d  = wptr_q + AW'(1);
          if (full) begin
            optr_d = optr_q + AW'(1);
            ovf_d  = 1'b1;
          end else begin
            cnt_d  = cnt_q + CW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ctrl_q       <= '0;
      trig_pc_q    <= '0;
      read_idx_q   <= '0;
      cnt_q        <= '0;
      wptr_q       <= '0;
      optr_q       <= '0;
      ovf_q        <= 1'b0;
      state_q      <= ST_IDLE;
      prev_state_q <= '0;
      ready_q      <= 1'b0;
      dat_q        <= '0;
    end else begin
      ctrl_q       <= ctrl_d;
      trig_pc_q    <= trig_pc_d;
      read_idx_q   <= read_idx_d;
      cnt_q        <= cnt_d;
      wptr_q       <= wptr_d;
      optr_q       <= optr_d;
      ovf_q        <= ovf_d;
      state_q      <= state_d;
      prev_state_q <= prev_state_d;
      ready_q      <= ready_d;
      dat_q        <= dat_d;
    end
  end

  assign bus_ready = ready_q;
  assign bus_dat_o = dat_q;

endmodule
